// File: rtl/mul_pipe_unit_if.sv
// Handshake bundle between the issue stage, the multiplier and write-back.
//   issue side : issue_new_request/issue_ready valid-ready pair, issue_id tag,
//                op (fn3 low bits plus word flag), rs1/rs2 operands, flush
//   wb side    : wb_done/wb_ack valid-ack pair, wb_id tag, wb_rd result
// master = issue + write-back logic driving the unit; slave = the unit itself.
interface mul_pipe_unit_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
);
  logic            issue_new_request;
  logic            issue_ready;
  logic [ID_W-1:0] issue_id;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            wb_done;
  logic [ID_W-1:0] wb_id;
  logic [XLEN-1:0] wb_rd;
  logic            wb_ack;

  modport master (
    output issue_new_request, issue_id, op, rs1, rs2, flush, wb_ack,
    input  issue_ready, wb_done, wb_id, wb_rd
  );

  modport slave (
    input  issue_new_request, issue_id, op, rs1, rs2, flush, wb_ack,
    output issue_ready, wb_done, wb_id, wb_rd
  );
endinterface

// File: rtl/mul_pipe_unit.sv
// Pipelined RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU, MULW when XLEN=64).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset, clears every stage
//   bus  - mul_pipe_unit_if.slave: issue handshake in, write-back handshake out
// Stage 0 holds the extended operands, stage 1 holds the full product and stages
// 2..LATENCY-1 only carry it so synthesis can retime the multiplier across them.
// Each stage advances when it is empty or the stage after it advances, so bubbles
// collapse under a write-back stall and a full pipeline streams one op per cycle.
module mul_pipe_unit #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int ID_W    = 3
) (
  input logic           clk,
  input logic           rst,
  mul_pipe_unit_if.slave bus
);

  // Product of two (XLEN+1)-bit signed operands, kept at full width.
  localparam int PW = 2 * XLEN + 2;

  localparam logic [1:0] SEL_LO   = 2'd0;
  localparam logic [1:0] SEL_HI   = 2'd1;
  localparam logic [1:0] SEL_WORD = 2'd2;

  logic [LATENCY-1:0]    adv;
  logic [LATENCY-1:0]    v_q, v_d;
  logic [ID_W-1:0]       id_q  [LATENCY];
  logic [ID_W-1:0]       id_d  [LATENCY];
  logic [1:0]            sel_q [LATENCY];
  logic [1:0]            sel_d [LATENCY];
  logic signed [XLEN:0]  a_q, a_d, b_q, b_d;
  logic signed [PW-1:0]  prod_q [1:LATENCY-1];
  logic signed [PW-1:0]  prod_d [1:LATENCY-1];

  logic                  word_op, sx_rs1, sx_rs2;
  logic [1:0]            sel_new;
  logic signed [PW-1:0]  a_ext, b_ext;
  logic signed [PW-1:0]  p_last;
  logic signed [31:0]    word_lo;
  logic [XLEN-1:0]       rd;
  logic                  unused_prod_msbs;

  // Advance chain, resolved from the write-back end backwards.
  always_comb begin
    adv = '0;
    adv[LATENCY-1] = ~v_q[LATENCY-1] | bus.wb_ack;
    for (int i = LATENCY - 2; i >= 0; i--) begin
      adv[i] = ~v_q[i] | adv[i+1];
    end
  end

  assign bus.issue_ready = adv[0];

  // Word mode only exists for RV64; on RV32 op[2] has no effect.
  always_comb begin
    word_op = (XLEN == 64) && bus.op[2];
    sx_rs1  = ~word_op && ((bus.op[1:0] == 2'b01) || (bus.op[1:0] == 2'b10));
    sx_rs2  = ~word_op && ((bus.op[1:0] == 2'b00) || (bus.op[1:0] == 2'b01));
    if (word_op) begin
      sel_new = SEL_WORD;
    end else if (bus.op[1:0] == 2'b00) begin
      sel_new = SEL_LO;
    end else begin
      sel_new = SEL_HI;
    end
  end

  always_comb begin
    a_ext = PW'(a_q);
    b_ext = PW'(b_q);
  end

  always_comb begin
    v_d = v_q;
    a_d = a_q;
    b_d = b_q;
    for (int i = 0; i < LATENCY; i++) begin
      id_d[i]  = id_q[i];
      sel_d[i] = sel_q[i];
    end
    for (int i = 1; i < LATENCY; i++) begin
      prod_d[i] = prod_q[i];
    end

    if (adv[0]) begin
      v_d[0]   = bus.issue_new_request;
      id_d[0]  = bus.issue_id;
      sel_d[0] = sel_new;
      if (word_op) begin
        // Only the low product word is returned, so zero-extension is enough.
        a_d = {{(XLEN-31){1'b0}}, bus.rs1[31:0]};
        b_d = {{(XLEN-31){1'b0}}, bus.rs2[31:0]};
      end else begin
        a_d = {sx_rs1 & bus.rs1[XLEN-1], bus.rs1};
        b_d = {sx_rs2 & bus.rs2[XLEN-1], bus.rs2};
      end
    end

    if (adv[1]) begin
      v_d[1]    = v_q[0];
      id_d[1]   = id_q[0];
      sel_d[1]  = sel_q[0];
      prod_d[1] = a_ext * b_ext;
    end

    for (int i = 2; i < LATENCY; i++) begin
      if (adv[i]) begin
        v_d[i]    = v_q[i-1];
        id_d[i]   = id_q[i-1];
        sel_d[i]  = sel_q[i-1];
        prod_d[i] = prod_q[i-1];
      end
    end

    // Flush kills valids only, including a request offered this cycle.
    if (bus.flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        id_q[i]  <= '0;
        sel_q[i] <= SEL_LO;
      end
      for (int i = 1; i < LATENCY; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      for (int i = 0; i < LATENCY; i++) begin
        id_q[i]  <= id_d[i];
        sel_q[i] <= sel_d[i];
      end
      for (int i = 1; i < LATENCY; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  // Result select straight off the last stage registers, so outputs hold under stall.
  always_comb begin
    p_last  = prod_q[LATENCY-1];
    word_lo = p_last[31:0];
    case (sel_q[LATENCY-1])
      SEL_HI:   rd = p_last[2*XLEN-1:XLEN];
      SEL_WORD: rd = XLEN'(word_lo);
      default:  rd = p_last[XLEN-1:0];
    endcase
  end

  // The two product MSBs are only sign copies and never selected.
  assign unused_prod_msbs = ^p_last[PW-1:2*XLEN];

  assign bus.wb_done = v_q[LATENCY-1];
  assign bus.wb_id   = id_q[LATENCY-1];
  assign bus.wb_rd   = rd;

endmodule

// File: tb/tb_mul_pipe_unit.sv
module tb_mul_pipe_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_pipe_unit_if #(.XLEN(32), .ID_W(3)) ifa ();
  mul_pipe_unit_if #(.XLEN(64), .ID_W(3)) ifb ();

  mul_pipe_unit #(.XLEN(32), .LATENCY(2), .ID_W(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mul_pipe_unit #(.XLEN(64), .LATENCY(4), .ID_W(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] data;
  } sb_t;

  sb_t qa[$];
  sb_t qb[$];
  sb_t pend_a, pend_b;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int xlen, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, p;
    logic [31:0] w;
    logic [63:0] lo64;
    logic sgn_a, sgn_b;
    sgn_a = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
    sgn_b = (op[1:0] == 2'b01);
    if (xlen == 64 && op[2]) begin
      w = a[31:0] * b[31:0];
      return {{32{w[31]}}, w};
    end
    if (op[1:0] == 2'b00) begin
      lo64 = a * b;
      return (xlen == 32) ? {32'd0, lo64[31:0]} : lo64;
    end
    if (xlen == 32) begin
      sa = sgn_a ? {{98{a[31]}}, a[31:0]} : {98'd0, a[31:0]};
      sb = sgn_b ? {{98{b[31]}}, b[31:0]} : {98'd0, b[31:0]};
      p  = sa * sb;
      return {32'd0, p[63:32]};
    end
    sa = sgn_a ? {{66{a[63]}}, a} : {66'd0, a};
    sb = sgn_b ? {{66{b[63]}}, b} : {66'd0, b};
    p  = sa * sb;
    return p[127:64];
  endfunction

  function automatic logic [63:0] pick(input int k);
    case (k % 6)
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_8000_0000;
      4:       return 64'h7FFF_FFFF_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic req_a(input logic [2:0] id, input logic [2:0] op,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [63:0] exp);
    ifa.issue_new_request = 1'b1;
    ifa.issue_id = id;
    ifa.op = op;
    ifa.rs1 = r1;
    ifa.rs2 = r2;
    pend_a = {id, exp};
  endtask

  task automatic req_b(input logic [2:0] id, input logic [2:0] op,
                       input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] exp);
    ifb.issue_new_request = 1'b1;
    ifb.issue_id = id;
    ifb.op = op;
    ifb.rs1 = r1;
    ifb.rs2 = r2;
    pend_b = {id, exp};
  endtask

  // Scoreboard bookkeeping for the current cycle, then advance one clock.
  task automatic cycle();
    sb_t e;
    #1;
    if (ifa.wb_done && ifa.wb_ack && !ifa.flush) begin
      if (qa.size() == 0) chk("a_spurious_wb", 64'(ifa.wb_done), 64'd0);
      else begin
        e = qa.pop_front();
        chk("a_wb_id", 64'(ifa.wb_id), 64'(e.id));
        chk("a_wb_rd", 64'(ifa.wb_rd), e.data);
      end
    end
    if (ifa.flush) qa.delete();
    if (ifa.issue_new_request && ifa.issue_ready && !ifa.flush) qa.push_back(pend_a);
    if (ifb.wb_done && ifb.wb_ack && !ifb.flush) begin
      if (qb.size() == 0) chk("b_spurious_wb", 64'(ifb.wb_done), 64'd0);
      else begin
        e = qb.pop_front();
        chk("b_wb_id", 64'(ifb.wb_id), 64'(e.id));
        chk("b_wb_rd", ifb.wb_rd, e.data);
      end
    end
    if (ifb.flush) qb.delete();
    if (ifb.issue_new_request && ifb.issue_ready && !ifb.flush) qb.push_back(pend_b);
    @(posedge clk);
    #1;
    ifa.issue_new_request = 1'b0;
    ifa.flush = 1'b0;
    ifb.issue_new_request = 1'b0;
    ifb.flush = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] r1, r2;
    rst = 1'b0;
    ifa.issue_new_request = 1'b0; ifa.issue_id = '0; ifa.op = '0;
    ifa.rs1 = '0; ifa.rs2 = '0; ifa.flush = 1'b0; ifa.wb_ack = 1'b1;
    ifb.issue_new_request = 1'b0; ifb.issue_id = '0; ifb.op = '0;
    ifb.rs1 = '0; ifb.rs2 = '0; ifb.flush = 1'b0; ifb.wb_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("a_rst_done",  64'(ifa.wb_done), 64'd0);
    chk("a_rst_id",    64'(ifa.wb_id), 64'd0);
    chk("a_rst_rd",    64'(ifa.wb_rd), 64'd0);
    chk("a_rst_ready", 64'(ifa.issue_ready), 64'd1);
    chk("b_rst_done",  64'(ifb.wb_done), 64'd0);
    chk("b_rst_rd",    ifb.wb_rd, 64'd0);
    chk("b_rst_ready", 64'(ifb.issue_ready), 64'd1);

    // T1: MUL 7*6, two-cycle latency
    req_a(3'd5, 3'b000, 32'd7, 32'd6, 64'h2A);
    cycle();
    chk("t1_done_early", 64'(ifa.wb_done), 64'd0);
    cycle();
    chk("t1_done", 64'(ifa.wb_done), 64'd1);
    chk("t1_id",   64'(ifa.wb_id), 64'd5);
    chk("t1_rd",   64'(ifa.wb_rd), 64'h2A);
    cycle();

    // T2: high-half variants, back to back; op[2] ignored on RV32
    req_a(3'd1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);        cycle();
    req_a(3'd2, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE); cycle();
    req_a(3'd3, 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF); cycle();
    req_a(3'd4, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE); cycle();
    repeat (3) cycle();

    // Mixed sweep on both widths against the reference model
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      r1 = pick(i);
      r2 = pick(i + 3);
      req_a(3'(i), op, r1[31:0], r2[31:0], ref_mul(32, op, r1, r2));
      req_b(3'(i), op, r1, r2, ref_mul(64, op, r1, r2));
      cycle();
    end
    repeat (6) cycle();

    // T3: LATENCY=4, four back-to-back ops into a stalled write-back
    ifb.wb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_b(3'(i), 3'b000, 64'(i + 10), 64'd3, 64'((i + 10) * 3));
      cycle();
    end
    chk("t3_full_ready", 64'(ifb.issue_ready), 64'd0);
    chk("t3_done", 64'(ifb.wb_done), 64'd1);
    chk("t3_id0",  64'(ifb.wb_id), 64'd0);
    chk("t3_rd0",  ifb.wb_rd, 64'd30);
    cycle();
    req_b(3'd7, 3'b000, 64'd1, 64'd1, 64'd1);
    #1;
    chk("t3_stall_ready", 64'(ifb.issue_ready), 64'd0);
    chk("t3_hold_id", 64'(ifb.wb_id), 64'd0);
    chk("t3_hold_rd", ifb.wb_rd, 64'd30);
    cycle();
    chk("t3_hold_done", 64'(ifb.wb_done), 64'd1);
    chk("t3_hold_rd2",  ifb.wb_rd, 64'd30);
    cycle();
    ifb.wb_ack = 1'b1;
    req_b(3'd4, 3'b000, 64'd20, 64'd3, 64'd60);
    #1;
    chk("t3_ready_drain", 64'(ifb.issue_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_stream_done", 64'(ifb.wb_done), 64'd1);
      chk("t3_stream_id",   64'(ifb.wb_id), 64'(k + 1));
    end
    cycle();
    chk("t3_empty", 64'(ifb.wb_done), 64'd0);

    // Bubble collapse: one op stalled at the end, three more still accepted
    ifb.wb_ack = 1'b0;
    req_b(3'd6, 3'b000, 64'd5, 64'd5, 64'd25);
    cycle();
    repeat (5) cycle();
    for (int k = 0; k < 3; k++) begin
      req_b(3'(k), 3'b000, 64'(k), 64'd2, 64'(2 * k));
      chk("bub_ready", 64'(ifb.issue_ready), 64'd1);
      cycle();
    end
    chk("bub_full", 64'(ifb.issue_ready), 64'd0);
    ifb.wb_ack = 1'b1;
    repeat (6) cycle();

    // T4: RV64 word mode
    req_b(3'd1, 3'b100, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle();
    req_b(3'd2, 3'b111, 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_0000_0005, 64'hF);
    cycle();
    repeat (5) cycle();

    // T5: flush with three in flight plus a fresh request
    for (int i = 0; i < 3; i++) begin
      req_b(3'(i + 1), 3'b011, 64'(i + 1), 64'd7, 64'd0);
      cycle();
    end
    req_b(3'd4, 3'b000, 64'd2, 64'd2, 64'd4);
    ifb.flush = 1'b1;
    cycle();
    for (int k = 0; k < 6; k++) begin
      chk("t5_no_wb", 64'(ifb.wb_done), 64'd0);
      cycle();
    end
    req_b(3'd5, 3'b000, 64'd9, 64'd9, 64'd81);
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk("t5_lat_early", 64'(ifb.wb_done), 64'd0);
      cycle();
    end
    chk("t5_lat_done", 64'(ifb.wb_done), 64'd1);
    chk("t5_lat_id",   64'(ifb.wb_id), 64'd5);
    chk("t5_lat_rd",   ifb.wb_rd, 64'd81);
    cycle();

    // T6: asynchronous reset while a result is stalled at write-back
    ifb.wb_ack = 1'b0;
    req_b(3'd6, 3'b000, 64'h11, 64'h3, 64'h33);
    cycle();
    repeat (4) cycle();
    chk("t6_pre_done", 64'(ifb.wb_done), 64'd1);
    chk("t6_pre_id",   64'(ifb.wb_id), 64'd6);
    chk("t6_pre_rd",   ifb.wb_rd, 64'h33);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_done", 64'(ifb.wb_done), 64'd0);
    chk("t6_async_id",   64'(ifb.wb_id), 64'd0);
    chk("t6_async_rd",   ifb.wb_rd, 64'd0);
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ifb.wb_ack = 1'b1;
    cycle();
    chk("t6_after_done", 64'(ifb.wb_done), 64'd0);

    chk("a_sb_empty", 64'(qa.size()), 64'd0);
    chk("b_sb_empty", 64'(qb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
